// File: rtl/h264_bitreader.sv
// h264_bitreader: Annex-B byte consumer with start-code detection and
// emulation-prevention removal, serving u(n)/ue(v)/se(v)/align reads.
module h264_bitreader #(
   parameter int MAXFIX = 24,
   parameter int MAXLZ  = 11
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        STROBEI,
   input  logic [7:0]  BYTEI,
   output logic        READYI,
   input  logic        EOS,
   input  logic        REQ,
   input  logic [1:0]  MODE,
   input  logic [4:0]  NBITS,
   output logic        BUSY,
   output logic        VALID,
   output logic [23:0] VALUE,
   output logic [4:0]  LEN,
   output logic        ERR,
   output logic        STARTO
);

   localparam logic [5:0] MAXFIX_W = 6'(MAXFIX);
   localparam logic [5:0] MAXLZ_W  = 6'(MAXLZ);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] win;
   logic [5:0]  cnt;
   logic [1:0]  zrun;
   logic [1:0]  r_mode;
   logic [4:0]  r_nbits;
   logic        accept, is_start, is_drop, do_app, fire;
   logic        s_done, s_err;
   logic [4:0]  s_len;
   logic [23:0] s_val;
   logic [5:0]  lz;
   logic [6:0]  ue_len;
   logic [23:0] code;
   logic [23:0] k;
   logic [5:0]  cnt_sh;
   logic [31:0] win_sh;

   // Invalid bits below the window are kept zero, so a plain scan works.
   always_comb begin
      lz = 6'd32;
      for (int i = 0; i < 32; i++)
         if (win[i]) lz = 6'(31 - i);
   end

   assign READYI   = (cnt <= 6'd24);
   assign accept   = STROBEI && READYI;
   assign is_start = accept && (zrun == 2'd2) && (BYTEI == 8'h01);
   assign is_drop  = accept && (zrun == 2'd2) && (BYTEI == 8'h03);
   assign do_app   = accept && !is_start && !is_drop;

   always_comb begin
      s_done = 1'b0;
      s_err  = 1'b0;
      s_len  = 5'd0;
      s_val  = 24'd0;
      ue_len = {lz, 1'b1};
      code   = 24'(win >> (7'd32 - ue_len));
      k      = code - 24'd1;
      unique case (r_mode)
         2'b00: begin
            if (r_nbits == 5'd0 || {1'b0, r_nbits} > MAXFIX_W) begin
               s_done = 1'b1;
               s_err  = 1'b1;
            end else if (cnt >= {1'b0, r_nbits}) begin
               s_done = 1'b1;
               s_len  = r_nbits;
               s_val  = 24'(win >> (6'd32 - {1'b0, r_nbits}));
            end
         end
         2'b01, 2'b10: begin
            if (lz > MAXLZ_W && cnt > MAXLZ_W) begin
               s_done = 1'b1;
               s_err  = 1'b1;
            end else if (lz < cnt && {1'b0, cnt} >= ue_len) begin
               s_done = 1'b1;
               s_len  = ue_len[4:0];
               if (r_mode == 2'b01)
                  s_val = k;
               else if (k[0])
                  s_val = (k + 24'd1) >> 1;
               else
                  s_val = 24'd0 - (k >> 1);
            end
         end
         2'b11: begin
            s_done = 1'b1;
            s_len  = {2'b00, cnt[2:0]};
            s_val  = 24'(win >> (6'd32 - {3'b000, cnt[2:0]}));
         end
      endcase
      if (!s_done && EOS) begin
         s_done = 1'b1;
         s_err  = 1'b1;
      end
      // A start code invalidates whatever the request was waiting on.
      if (is_start) begin
         s_done = 1'b1;
         s_err  = 1'b1;
         s_len  = 5'd0;
         s_val  = 24'd0;
      end
   end

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) state <= S_IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (REQ)    state_nx = S_WAIT;
         S_WAIT: if (s_done) state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state == S_WAIT);
      fire = (state == S_WAIT) && s_done;
   end

   assign cnt_sh = cnt - (fire ? {1'b0, s_len} : 6'd0);
   assign win_sh = fire ? (win << s_len) : win;

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         win  <= 32'd0;
         cnt  <= 6'd0;
         zrun <= 2'd0;
      end else begin
         if (is_start) begin
            win <= 32'd0;
            cnt <= 6'd0;
         end else if (do_app) begin
            win <= win_sh | ({BYTEI, 24'd0} >> cnt_sh);
            cnt <= cnt_sh + 6'd8;
         end else begin
            win <= win_sh;
            cnt <= cnt_sh;
         end
         if (accept)
            zrun <= (BYTEI != 8'h00) ? 2'd0 :
                    (zrun == 2'd2)   ? 2'd2 : zrun + 2'd1;
      end

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         r_mode  <= 2'd0;
         r_nbits <= 5'd0;
      end else if (state == S_IDLE && REQ) begin
         r_mode  <= MODE;
         r_nbits <= NBITS;
      end

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         VALID  <= 1'b0;
         ERR    <= 1'b0;
         VALUE  <= 24'd0;
         LEN    <= 5'd0;
         STARTO <= 1'b0;
      end else begin
         VALID  <= fire;
         ERR    <= fire && s_err;
         VALUE  <= fire ? s_val : 24'd0;
         LEN    <= fire ? s_len : 5'd0;
         STARTO <= is_start;
      end

endmodule

// File: tb/tb_h264_bitreader.sv
// tb_h264_bitreader: directed byte/request sequences with hand-computed
// results for h264_bitreader.
module tb_h264_bitreader;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        STROBEI;
   logic [7:0]  BYTEI;
   logic        READYI;
   logic        EOS;
   logic        REQ;
   logic [1:0]  MODE;
   logic [4:0]  NBITS;
   logic        BUSY;
   logic        VALID;
   logic [23:0] VALUE;
   logic [4:0]  LEN;
   logic        ERR;
   logic        STARTO;

   int checks = 0;
   int errors = 0;
   int starto_n = 0;

   h264_bitreader dut (
      .CLK(CLK), .RESETN(RESETN), .STROBEI(STROBEI), .BYTEI(BYTEI),
      .READYI(READYI), .EOS(EOS), .REQ(REQ), .MODE(MODE), .NBITS(NBITS),
      .BUSY(BUSY), .VALID(VALID), .VALUE(VALUE), .LEN(LEN), .ERR(ERR),
      .STARTO(STARTO)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (STARTO) starto_n++;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      bit done;
      done = 1'b0;
      STROBEI = 1'b1;
      BYTEI   = b;
      for (int i = 0; i < 20 && !done; i++) begin
         if (READYI) done = 1'b1;
         tick();
      end
      STROBEI = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL put_timeout obs=%0h exp=accepted", b);
      end
   endtask

   task automatic req(input logic [1:0] m, input logic [4:0] n);
      REQ   = 1'b1;
      MODE  = m;
      NBITS = n;
      tick();
      REQ = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic e_err,
                             input logic [23:0] e_val, input logic [4:0] e_len);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (VALID) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $error("FAIL %s_timeout obs=novalid exp=valid", tag);
      end else begin
         chk({tag, "_err"}, 32'(ERR), 32'(e_err));
         chk({tag, "_val"}, 32'(VALUE), 32'(e_val));
         chk({tag, "_len"}, 32'(LEN), 32'(e_len));
         chk({tag, "_busy"}, 32'(BUSY), 32'd0);
      end
   endtask

   initial begin
      RESETN  = 1'b0;
      STROBEI = 1'b0;
      BYTEI   = 8'h00;
      EOS     = 1'b0;
      REQ     = 1'b0;
      MODE    = 2'b00;
      NBITS   = 5'd0;
      #7;
      chk("rst_ready", 32'(READYI), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_valid", 32'(VALID), 32'd0);
      chk("rst_value", 32'(VALUE), 32'd0);
      chk("rst_len", 32'(LEN), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_starto", 32'(STARTO), 32'd0);
      #5 RESETN = 1'b1;
      tick();

      // fixed-length reads across a byte boundary
      put(8'hA5);
      put(8'h3C);
      req(2'b00, 5'd4);  expect_res("u4a", 1'b0, 24'hA, 5'd4);
      req(2'b00, 5'd8);  expect_res("u8", 1'b0, 24'h53, 5'd8);
      req(2'b00, 5'd4);  expect_res("u4b", 1'b0, 24'hC, 5'd4);
      req(2'b11, 5'd0);  expect_res("empty_align", 1'b0, 24'h0, 5'd0);

      // emulation-prevention byte removed
      put(8'h00); put(8'h00); put(8'h03); put(8'h01);
      req(2'b00, 5'd24); expect_res("epb_u24", 1'b0, 24'h000001, 5'd24);
      chk("epb_nostart", 32'(starto_n), 32'd0);

      // start code while a u(24) waits on 16 buffered bits
      put(8'h00); put(8'h00);
      req(2'b00, 5'd24);
      chk("sc_pending", 32'(BUSY), 32'd1);
      put(8'h01);
      chk("sc_valid", 32'(VALID), 32'd1);
      chk("sc_err", 32'(ERR), 32'd1);
      chk("sc_len", 32'(LEN), 32'd0);
      chk("sc_starto", 32'(STARTO), 32'd1);
      tick();
      chk("sc_starto_off", 32'(STARTO), 32'd0);
      put(8'h9F);
      req(2'b00, 5'd8);  expect_res("sc_after", 1'b0, 24'h9F, 5'd8);

      // ue 00111 -> 6, then 000 left with EOS
      put(8'h38);
      req(2'b01, 5'd0);  expect_res("ue6", 1'b0, 24'd6, 5'd5);
      EOS = 1'b1;
      req(2'b01, 5'd0);  expect_res("ue_eos", 1'b1, 24'd0, 5'd0);
      EOS = 1'b0;
      req(2'b11, 5'd0);  expect_res("eos_align", 1'b0, 24'd0, 5'd3);

      // se 011 -> -1, se 010 -> +1, each followed by align of 10000
      put(8'h70);
      req(2'b10, 5'd0);  expect_res("se_m1", 1'b0, 24'hFFFFFF, 5'd3);
      req(2'b11, 5'd0);  expect_res("align5a", 1'b0, 24'h10, 5'd5);
      put(8'h50);
      req(2'b10, 5'd0);  expect_res("se_p1", 1'b0, 24'h000001, 5'd3);
      req(2'b11, 5'd0);  expect_res("align5b", 1'b0, 24'h10, 5'd5);

      // illegal sizes and an over-long prefix
      req(2'b00, 5'd0);  expect_res("u0_err", 1'b1, 24'd0, 5'd0);
      req(2'b00, 5'd25); expect_res("u25_err", 1'b1, 24'd0, 5'd0);
      put(8'h00); put(8'h00); put(8'h08);
      req(2'b01, 5'd0);  expect_res("lz20_err", 1'b1, 24'd0, 5'd0);
      req(2'b00, 5'd24); expect_res("lz20_keep", 1'b0, 24'h000008, 5'd24);
      put(8'h80);
      req(2'b01, 5'd0);  expect_res("ue0", 1'b0, 24'd0, 5'd1);
      req(2'b11, 5'd0);  expect_res("align7", 1'b0, 24'd0, 5'd7);

      // fill to 32 bits, then consume while a byte waits
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      chk("full_ready", 32'(READYI), 32'd0);
      STROBEI = 1'b1;
      BYTEI   = 8'h55;
      req(2'b00, 5'd8);  expect_res("full_u8a", 1'b0, 24'h11, 5'd8);
      req(2'b00, 5'd8);
      STROBEI = 1'b0;
      chk("refill_ready", 32'(READYI), 32'd0);
      expect_res("full_u8b", 1'b0, 24'h22, 5'd8);
      req(2'b00, 5'd8);
      STROBEI = 1'b1;
      BYTEI   = 8'h66;
      expect_res("same_cyc_u8", 1'b0, 24'h33, 5'd8);
      STROBEI = 1'b0;
      chk("same_cyc_ready", 32'(READYI), 32'd1);
      req(2'b00, 5'd24); expect_res("tail_u24", 1'b0, 24'h445566, 5'd24);

      // asynchronous reset drops a pending request
      put(8'hC3);
      req(2'b00, 5'd24);
      chk("mid_busy", 32'(BUSY), 32'd1);
      #2 RESETN = 1'b0;
      #2;
      chk("mid_rst_busy", 32'(BUSY), 32'd0);
      chk("mid_rst_ready", 32'(READYI), 32'd1);
      RESETN = 1'b1;
      tick();
      tick();
      chk("mid_no_valid", 32'(VALID), 32'd0);
      put(8'hAB);
      req(2'b00, 5'd8);  expect_res("post_rst_u8", 1'b0, 24'hAB, 5'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
